serial_wide_adder: RTL and testbench
====================================

Name: serial_wide_adder

Overview:
- Multi-byte adder that drives one existing adder8 instance over several cycles, least-significant byte first.
- The adder8 cout of each byte is registered and fed back as the next byte's cin.
- Sits directly around adder8: it supplies x/y/cin to adder8 and consumes its sum/cout.
- Gives the datapath NBYTES*8-bit addition at the area cost of a single 8-bit adder.

Parameters:
- NBYTES, 4, number of 8-bit limbs per operand; legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- a  input  8*NBYTES  operand A; sampled on acceptance.
- b  input  8*NBYTES  operand B; sampled on acceptance.
- cin  input  1  initial carry-in; sampled on acceptance.
- ready  output  1  block can accept start this cycle.
- done  output  1  one-cycle pulse; result valid.
- sum  output  8*NBYTES  result; held stable from done until the next acceptance.
- cout  output  1  final carry out; held with sum.

Behaviour:
- Reset (rst=1 at a clock edge, from any state):
  - state=IDLE, ready=1, done=0, sum=0, cout=0.
  - Operand registers, carry register and byte index cleared.
  - Any in-flight operation is abandoned; no done is produced for it.
- Acceptance: start && ready at edge T.
  - Latch a, b into shift registers; carry_q<=cin; idx<=0; state<=RUN.
- States and transitions:
  - IDLE: ready=1, done=0. Acceptance -> RUN.
  - RUN: ready=0, done=0. Each cycle adder8 gets x=a_q[7:0], y=b_q[7:0], cin=carry_q.
    - At the edge: the adder8 sum byte is written into sum_q[8*idx +: 8] (overwrite); the adder8 cout goes to carry_q; a_q, b_q shift right by 8; idx++.
    - When idx==NBYTES-1 at the edge -> DONE, and cout<=adder8 cout.
  - DONE: done=1 for exactly this cycle, ready=1. Acceptance -> RUN; otherwise -> IDLE.
- Latency: acceptance at edge T; RUN occupies cycles T+1..T+NBYTES; done is high in cycle T+NBYTES+1. Back-to-back throughput: one result per NBYTES+1 cycles.
- sum/cout update only at the final RUN edge. Intermediate bytes go to sum_q but are not visible: the sum output is driven from a holding register loaded only on the RUN->DONE edge.
- start while ready=0 is ignored; no queueing.
- NBYTES=1: a single RUN cycle, then DONE.
- Arithmetic is modulo 2^(8*NBYTES); cout is the carry out of bit 8*NBYTES-1.
- No X allowed on outputs after the first reset.

Optional Feature:
- Macro: SERIAL_WIDE_ADDER_SUB_EN.
- Enabled:
  - Adds input port sub (1 bit), sampled on acceptance.
  - When sub=1, b is bit-inverted as it is latched and carry_q<=1 (cin ignored), so sum = a - b modulo 2^(8*NBYTES).
  - cout=1 means no borrow (a>=b, unsigned).
  - sub=0 behaves exactly as the base block.
- Disabled: no sub port; addition only.

Decomposition:
- Package serial_wide_adder_pkg holds:
  - BYTE_W=8 constant.
  - State enum (IDLE, RUN, DONE), 2-bit encoding.
  - Helper function for the index width, $clog2 of NBYTES with a minimum of 1.
- Sub-module: the existing adder8, instantiated once with ports x, y, cin, sum, cout. No new sub-module.

Test Plan (NBYTES=4 unless stated):
- Basic add: a=32'h0000000C, b=32'h00000005, cin=0, start pulsed once -> ready drops next cycle; done in cycle T+5; sum=32'h00000011, cout=0; returns to IDLE; sum held.
- Full carry ripple: a=32'hFFFFFFFF, b=32'h00000001, cin=0 -> sum=32'h00000000, cout=1.
- Carry-in and inter-byte carries: a=32'h00FF00FF, b=32'h00010001, cin=1 -> sum=32'h01000101, cout=0.
- Start while busy and back-to-back:
  - Assert start every cycle with changing operands -> only the operands presented while IDLE/DONE are accepted.
  - Second result's done arrives exactly 5 cycles after the first.
  - Operands presented during RUN have no effect.
- Reset mid-operation: rst=1 in cycle T+2 for one cycle -> next cycle ready=1, done=0, sum=0, cout=0; no done for the abandoned op; a fresh add (7+9) yields 32'h00000010.
- With SERIAL_WIDE_ADDER_SUB_EN: a=5, b=12, sub=1 -> sum=32'hFFFFFFF9, cout=0; a=12, b=5, sub=1 -> sum=32'h00000007, cout=1. NBYTES=1 build: a=8'hF0, b=8'h20 -> done at T+2, sum=8'h10, cout=1.

Source files
------------

// File: rtl/serial_wide_adder_pkg.sv
// Shared constants, state encoding and index-width helper for serial_wide_adder.
package serial_wide_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte-index width, never narrower than one bit so NBYTES=1 still builds.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_wide_adder_adder8.sv
// The existing 8-bit ripple adder reused by serial_wide_adder, one byte per cycle.
module adder8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  assign {cout, sum} = 9'(x) + 9'(y) + 9'(cin);

endmodule

// File: rtl/serial_wide_adder.sv
// NBYTES*8-bit adder built on one adder8, LSB byte first, carry registered between bytes.
// Define SERIAL_WIDE_ADDER_SUB_EN to add the 'sub' port (a - b via inverted b and carry-in 1).
//
// state | meaning
// IDLE  | waiting for start, ready=1
// RUN   | one byte per cycle through adder8, ready=0
// DONE  | result valid for one cycle, ready=1 (back-to-back start accepted)
module serial_wide_adder
  import serial_wide_adder_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
`ifdef SERIAL_WIDE_ADDER_SUB_EN
  input  logic                     sub,
`endif
  output logic                     ready,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int IW = idx_w(NBYTES);

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic [W-1:0]    sum_nxt;
  logic            carry_q;
  logic [IW-1:0]   idx;

  logic [W-1:0]    b_lat;
  logic            cin_lat;
  logic [7:0]      s8;
  logic            c8;
  logic            accept;
  logic            last;

  assign accept = start && ready;
  assign last   = (idx == IW'(NBYTES - 1));

  always_comb begin
    b_lat   = b;
    cin_lat = cin;
`ifdef SERIAL_WIDE_ADDER_SUB_EN
    if (sub) begin
      b_lat   = ~b;
      cin_lat = 1'b1;
    end
`endif
  end

  adder8 u_adder8 (
    .x    (a_q[7:0]),
    .y    (b_q[7:0]),
    .cin  (carry_q),
    .sum  (s8),
    .cout (c8)
  );

  // Working image including the byte produced this cycle; feeds the holding register on the last byte.
  always_comb begin
    sum_nxt = sum_q;
    sum_nxt[BYTE_W*idx +: BYTE_W] = s8;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (accept) begin
            a_q     <= a;
            b_q     <= b_lat;
            carry_q <= cin_lat;
            idx     <= '0;
            state   <= RUN;
            ready   <= 1'b0;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        RUN: begin
          sum_q   <= sum_nxt;
          carry_q <= c8;
          a_q     <= a_q >> BYTE_W;
          b_q     <= b_q >> BYTE_W;
          idx     <= idx + IW'(1);
          if (last) begin
            state <= DONE;
            ready <= 1'b1;
            done  <= 1'b1;
            sum   <= sum_nxt;
            cout  <= c8;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_wide_adder.sv
// Self-checking bench for serial_wide_adder (NBYTES=4); exercises sub when SERIAL_WIDE_ADDER_SUB_EN is defined.
module tb_serial_wide_adder;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         ready;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_wide_adder #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_WIDE_ADDER_SUB_EN
    .sub   (sub),
`endif
    .ready (ready),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Reference model: whole-word arithmetic, result appears NB edges after acceptance.
  logic         checking = 1'b0;
  logic         m_ready  = 1'b1;
  logic         m_done   = 1'b0;
  logic [W-1:0] m_sum    = '0;
  logic         m_cout   = 1'b0;
  logic [W:0]   m_pend   = '0;
  int           m_left   = 0;

  always @(posedge clk) begin
    if (rst) begin
      checking = 1'b1;
      m_ready  = 1'b1;
      m_done   = 1'b0;
      m_sum    = '0;
      m_cout   = 1'b0;
      m_left   = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done  = 1'b1;
          m_ready = 1'b1;
          m_sum   = m_pend[W-1:0];
          m_cout  = m_pend[W];
        end
      end else if (start && m_ready) begin
`ifdef SERIAL_WIDE_ADDER_SUB_EN
        if (sub) m_pend = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else     m_pend = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
`else
        m_pend = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
`endif
        m_left  = NB;
        m_ready = 1'b0;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("ready", 64'(ready), 64'(m_ready));
      chk("done",  64'(done),  64'(m_done));
      chk("sum",   64'(sum),   64'(m_sum));
      chk("cout",  64'(cout),  64'(m_cout));
    end
  end

  // One operation from IDLE; checks latency and result against hand-computed literals.
  task automatic run_op(input string name, input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic ci, input logic si, input logic [W-1:0] exp_s, input logic exp_c);
    int n;
    @(negedge clk);
    a = ai; b = bi; cin = ci; sub = si; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;
    chk({name, "_ready_drop"}, 64'(ready), 64'(0));
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(NB + 1));
    chk({name, "_sum"},  64'(sum),  64'(exp_s));
    chk({name, "_cout"}, 64'(cout), 64'(exp_c));
    repeat (3) @(negedge clk);
    chk({name, "_held"}, 64'(sum), 64'(exp_s));
  endtask

  initial begin
    int done_t[$];
    int dcount;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 64'(ready), 64'(1));
    chk("reset_done",  64'(done),  64'(0));
    chk("reset_sum",   64'(sum),   64'(0));
    chk("reset_cout",  64'(cout),  64'(0));
    rst = 1'b0;

    run_op("basic",  32'h0000000C, 32'h00000005, 1'b0, 1'b0, 32'h00000011, 1'b0);
    run_op("ripple", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1);
    run_op("carry",  32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 32'h01000101, 1'b0);

    // start held high with changing operands; only IDLE/DONE-cycle operands count.
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      if (done) done_t.push_back(i);
      start = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    chk("b2b_count", 64'(done_t.size() >= 3), 64'(1));
    for (int i = 1; i < done_t.size(); i++)
      chk("b2b_spacing", 64'(done_t[i] - done_t[i-1]), 64'(NB + 1));
    repeat (NB + 2) @(negedge clk);

    // Reset two cycles into an operation abandons it.
    a = 32'h12345678; b = 32'h11111111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 64'(ready), 64'(1));
    chk("mid_rst_done",  64'(done),  64'(0));
    chk("mid_rst_sum",   64'(sum),   64'(0));
    chk("mid_rst_cout",  64'(cout),  64'(0));
    rst = 1'b0;
    dcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("mid_rst_no_done", 64'(dcount), 64'(0));
    run_op("after_rst", 32'd7, 32'd9, 1'b0, 1'b0, 32'h00000010, 1'b0);

`ifdef SERIAL_WIDE_ADDER_SUB_EN
    run_op("sub_neg", 32'd5,  32'd12, 1'b0, 1'b1, 32'hFFFFFFF9, 1'b0);
    run_op("sub_pos", 32'd12, 32'd5,  1'b1, 1'b1, 32'h00000007, 1'b1);
`endif

    // Random traffic with occasional resets, checked by the model every cycle.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 79) == 0);
      start = ($urandom_range(0, 2) != 0);
      a = $urandom; b = $urandom; cin = 1'($urandom);
`ifdef SERIAL_WIDE_ADDER_SUB_EN
      sub = 1'($urandom);
`endif
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (NB + 3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
